// File: rtl/wb_mtimer_if.sv
// Wishbone pipelined bus bundle for the mtime/mtimecmp timer slave.
interface wb_mtimer_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [4:2]  adr;
    logic [31:0] dat_m;
    logic [31:0] dat_s;
    logic        ack;
    logic        err;
    logic        stall;

    modport master (output cyc, stb, we, sel, adr, dat_m, input  dat_s, ack, err, stall);
    modport slave  (input  cyc, stb, we, sel, adr, dat_m, output dat_s, ack, err, stall);
endinterface

// File: rtl/wb_mtimer.sv
// RISC-V style 64-bit mtime/mtimecmp timer on a Wishbone slave port, level irq_timer.
// Optional WB_MTIMER_SNAPSHOT_EN: MTIME_LO reads latch mtime[63:32] for atomic hi reads.
module wb_mtimer #(
    parameter int unsigned PRESCALE = 100
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_mtimer_if.slave    wb,
    output logic          irq_timer
);
    localparam logic [2:0]  A_MLO  = 3'd0;
    localparam logic [2:0]  A_MHI  = 3'd1;
    localparam logic [2:0]  A_CLO  = 3'd2;
    localparam logic [2:0]  A_CHI  = 3'd3;
    localparam logic [2:0]  A_CTRL = 3'd4;
    localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic        en_q, en_d;
    logic [15:0] ps_q, ps_d;
    logic        ack_q, err_q, irq_q;
    logic [31:0] dat_s_q, dat_s_d;
    logic [31:0] hi_rd;
    logic        req, bad, wr, rd, tick;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[b*8 +: 8] = sel[b] ? nw[b*8 +: 8] : old[b*8 +: 8];
        return r;
    endfunction

    assign req  = wb.cyc & wb.stb;
    assign bad  = wb.adr > A_CTRL;
    assign wr   = req & wb.we & ~bad;
    assign rd   = req & ~wb.we & ~bad;
    assign tick = en_q && (ps_q == PS_MAX);

    always_comb begin
        ps_d = 16'd0;
        if (en_q && !tick)
            ps_d = ps_q + 16'd1;
    end

    // A bus write to either mtime half overrides the tick; the other half holds.
    always_comb begin
        mtime_d = mtime_q;
        if (wr && wb.adr == A_MLO)
            mtime_d[31:0] = merge(mtime_q[31:0], wb.dat_m, wb.sel);
        else if (wr && wb.adr == A_MHI)
            mtime_d[63:32] = merge(mtime_q[63:32], wb.dat_m, wb.sel);
        else if (tick)
            mtime_d = mtime_q + 64'd1;
    end

    always_comb begin
        cmp_d = cmp_q;
        en_d  = en_q;
        if (wr && wb.adr == A_CLO)  cmp_d[31:0]  = merge(cmp_q[31:0], wb.dat_m, wb.sel);
        if (wr && wb.adr == A_CHI)  cmp_d[63:32] = merge(cmp_q[63:32], wb.dat_m, wb.sel);
        if (wr && wb.adr == A_CTRL && wb.sel[0]) en_d = wb.dat_m[0];
    end

`ifdef WB_MTIMER_SNAPSHOT_EN
    logic [31:0] shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (rd && wb.adr == A_MLO)
            shadow_d = mtime_q[63:32];
        else if (wr && wb.adr == A_MHI)
            shadow_d = merge(mtime_q[63:32], wb.dat_m, wb.sel);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shadow_q <= 32'd0;
        else        shadow_q <= shadow_d;
    end

    assign hi_rd = shadow_q;
`else
    assign hi_rd = mtime_q[63:32];
`endif

    always_comb begin
        dat_s_d = 32'd0;
        if (rd) begin
            case (wb.adr)
                A_MLO:   dat_s_d = mtime_q[31:0];
                A_MHI:   dat_s_d = hi_rd;
                A_CLO:   dat_s_d = cmp_q[31:0];
                A_CHI:   dat_s_d = cmp_q[63:32];
                A_CTRL:  dat_s_d = {31'd0, en_q};
                default: dat_s_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q <= 64'd0;
            cmp_q   <= '1;
            en_q    <= 1'b0;
            ps_q    <= 16'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_s_q <= 32'd0;
            irq_q   <= 1'b0;
        end else begin
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            en_q    <= en_d;
            ps_q    <= ps_d;
            ack_q   <= req & ~bad;
            err_q   <= req & bad;
            dat_s_q <= dat_s_d;
            irq_q   <= en_q && (mtime_q >= cmp_q);
        end
    end

    assign wb.ack    = ack_q;
    assign wb.err    = err_q;
    assign wb.dat_s  = dat_s_q;
    assign wb.stall  = 1'b0;
    assign irq_timer = irq_q;
endmodule

// File: tb/tb_wb_mtimer.sv
// Directed bench for wb_mtimer (PRESCALE=4): register map, counting, irq, errors, snapshot.
module tb_wb_mtimer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq;
    always #5 clk = ~clk;

    wb_mtimer_if bus();
    wb_mtimer #(.PRESCALE(4)) dut (.clk(clk), .rst_n(rst_n), .wb(bus), .irq_timer(irq));

    int checks = 0;
    int errors = 0;
    logic        r_ack, r_err;
    logic [31:0] r_dat;
    logic [31:0] d;

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  adr;
        logic [31:0] dat;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;
    vec_t tv[10];

    function automatic vec_t mk(input string n, input logic we, input logic [2:0] adr,
                                input logic [31:0] dat, input logic ea, input logic ee,
                                input logic [31:0] ed);
        vec_t v;
        v.name = n; v.we = we; v.adr = adr; v.dat = dat;
        v.exp_ack = ea; v.exp_err = ee; v.exp_dat = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; request is taken at the next posedge, response sampled at the following negedge.
    task automatic xfer(input logic we, input logic [2:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we;
        bus.adr = adr; bus.dat_m = dat; bus.sel = sel;
        @(negedge clk);
        r_ack = bus.ack; r_err = bus.err; r_dat = bus.dat_s;
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] adr, input logic [31:0] dat);
        xfer(1'b1, adr, dat, 4'hF);
        chk("wr_ack", {r_err, r_ack}, 2'b01);
    endtask

    task automatic rd(input string name, input logic [2:0] adr, input logic [31:0] exp);
        xfer(1'b0, adr, 32'd0, 4'hF);
        chk(name, {r_err, r_ack, r_dat}, {2'b01, exp});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        bus.sel = 4'h0; bus.adr = 3'd0; bus.dat_m = 32'd0;

        tv[0] = mk("rst_mtime_lo", 1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 32'h0000_0000);
        tv[1] = mk("rst_mtime_hi", 1'b0, 3'd1, 32'd0, 1'b1, 1'b0, 32'h0000_0000);
        tv[2] = mk("rst_cmp_lo",   1'b0, 3'd2, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        tv[3] = mk("rst_cmp_hi",   1'b0, 3'd3, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        tv[4] = mk("rst_ctrl",     1'b0, 3'd4, 32'd0, 1'b1, 1'b0, 32'h0000_0000);
        tv[5] = mk("err_rd_14",    1'b0, 3'd5, 32'd0, 1'b0, 1'b1, 32'h0000_0000);
        tv[6] = mk("err_wr_18",    1'b1, 3'd6, 32'h1, 1'b0, 1'b1, 32'h0000_0000);
        tv[7] = mk("err_rd_1c",    1'b0, 3'd7, 32'd0, 1'b0, 1'b1, 32'h0000_0000);
        tv[8] = mk("b2b_rd_00",    1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 32'h0000_0000);
        tv[9] = mk("b2b_rd_10",    1'b0, 3'd4, 32'd0, 1'b1, 1'b0, 32'h0000_0000);

        idle(3);
        rst_n = 1'b1;
        chk("rst_irq", irq, 1'b0);

        // Reset map, error offsets and back-to-back acks
        for (int i = 0; i < 10; i++) begin
            xfer(tv[i].we, tv[i].adr, tv[i].dat, 4'hF);
            chk(tv[i].name, {r_err, r_ack, r_dat}, {tv[i].exp_err, tv[i].exp_ack, tv[i].exp_dat});
        end
        idle(1);
        chk("ack_one_cycle", {bus.err, bus.ack}, 2'b00);

        // Counting to mtimecmp and irq latency
        wr(3'd2, 32'd3);
        wr(3'd3, 32'd0);
        wr(3'd4, 32'd1);
        chk("irq_low_start", irq, 1'b0);
        idle(12);
        chk("irq_low_before", irq, 1'b0);
        idle(1);
        chk("irq_high", irq, 1'b1);
        rd("mtime_eq_3", 3'd0, 32'd3);
        wr(3'd2, 32'd10);
        chk("irq_hold_1cyc", irq, 1'b1);
        idle(1);
        chk("irq_cleared", irq, 1'b0);
        wr(3'd4, 32'd0);

        // Carry lo -> hi
        wr(3'd0, 32'hFFFF_FFFF);
        wr(3'd1, 32'h0);
        wr(3'd4, 32'd1);
        idle(4);
        rd("carry_lo", 3'd0, 32'h0);
        rd("carry_hi", 3'd1, 32'h1);
        wr(3'd4, 32'd0);

        // 64-bit wrap
        wr(3'd0, 32'hFFFF_FFFF);
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd4, 32'd1);
        idle(4);
        rd("wrap_lo", 3'd0, 32'h0);
        rd("wrap_hi", 3'd1, 32'h0);
        wr(3'd4, 32'd0);

        // Bus write lands in the tick cycle and wins
        wr(3'd1, 32'h0);
        wr(3'd0, 32'h0);
        wr(3'd4, 32'd1);
        idle(3);
        wr(3'd0, 32'h55);
        rd("tick_wr_lo", 3'd0, 32'h55);
        rd("tick_wr_hi", 3'd1, 32'h0);
        wr(3'd4, 32'd0);

        // Byte-lane write
        xfer(1'b1, 3'd2, 32'hAABB_CCDD, 4'b0010);
        chk("sel_wr_ack", {r_err, r_ack}, 2'b01);
        rd("sel_byte1", 3'd2, 32'h0000_CC0A);

        // Lo then hi read across a tick
        wr(3'd1, 32'h1);
        wr(3'd0, 32'hFFFF_FFFF);
        wr(3'd4, 32'd1);
        idle(3);
        rd("snap_lo", 3'd0, 32'hFFFF_FFFF);
`ifdef WB_MTIMER_SNAPSHOT_EN
        rd("snap_hi", 3'd1, 32'h1);
`else
        rd("live_hi", 3'd1, 32'h2);
`endif

        // Reset with an ack pending
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 3'd4; bus.sel = 4'hF;
        @(posedge clk);
        #1;
        bus.cyc = 1'b0; bus.stb = 1'b0;
        chk("ack_pending", bus.ack, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("ack_dropped", bus.ack, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        rd("ctrl_after_rst", 3'd4, 32'd0);
        rd("mtime_after_rst", 3'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
